// File: rtl/countdown_timer.sv
// Four-digit BCD MM:SS countdown timer: loads a preset, decrements once per
// TICK_DIV clocks with borrow propagation, stops at 00:00 and flags expiry.
module countdown_timer #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        start_stop,
    output logic [15:0] q,
    output logic        running,
    output logic        expired,
    output logic        done_pulse
);

    localparam int PW = $clog2(TICK_DIV);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]    r_state;
    logic [15:0]   r_q;
    logic [PW-1:0] r_presc;
    logic          r_done_pulse;

    logic          w_tick;
    logic [15:0]   w_dec;
    logic [15:0]   w_clamped;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
        return (d > max) ? max : d;
    endfunction

    assign w_clamped = {clamp_digit(load_val[15:12], 4'd9),
                        clamp_digit(load_val[11:8],  4'd9),
                        clamp_digit(load_val[7:4],   4'd5),
                        clamp_digit(load_val[3:0],   4'd9)};

    assign w_tick = (r_state == S_RUN) && (r_presc == PW'(TICK_DIV - 1));

    // Borrow ripples from seconds-ones upward; a digit at zero reloads its
    // maximum (9 or 5) and passes the borrow on.
    always_comb begin
        w_dec = r_q;
        if (r_q[3:0] != 4'd0) begin
            w_dec[3:0] = r_q[3:0] - 4'd1;
        end else begin
            w_dec[3:0] = 4'd9;
            if (r_q[7:4] != 4'd0) begin
                w_dec[7:4] = r_q[7:4] - 4'd1;
            end else begin
                w_dec[7:4] = 4'd5;
                if (r_q[11:8] != 4'd0) begin
                    w_dec[11:8] = r_q[11:8] - 4'd1;
                end else begin
                    w_dec[11:8]  = 4'd9;
                    w_dec[15:12] = r_q[15:12] - 4'd1;
                end
            end
        end
    end

    // NOTE: every register here is written with <= so all updates in a cycle
    // see the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_q          <= 16'h0000;
            r_presc      <= '0;
            r_done_pulse <= 1'b0;
        end else begin
            r_done_pulse <= 1'b0;
            if (clear) begin
                r_state <= S_IDLE;
                r_q     <= 16'h0000;
                r_presc <= '0;
            end else if (load && (r_state != S_RUN)) begin
                r_state <= S_IDLE;
                r_q     <= w_clamped;
                r_presc <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start_stop && (r_q != 16'h0000)) begin
                            r_state <= S_RUN;
                            r_presc <= '0;
                        end
                    end
                    S_RUN: begin
                        if (w_tick) begin
                            r_q     <= w_dec;
                            r_presc <= '0;
                            if (r_q == 16'h0001) begin
                                r_state      <= S_DONE;
                                r_done_pulse <= 1'b1;
                            end else if (start_stop) begin
                                r_state <= S_PAUSED;
                            end
                        end else begin
                            r_presc <= r_presc + PW'(1);
                            if (start_stop) begin
                                r_state <= S_PAUSED;
                            end
                        end
                    end
                    S_PAUSED: begin
                        if (start_stop) begin
                            r_state <= S_RUN;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign q          = r_q;
    assign running    = (r_state == S_RUN);
    assign expired    = (r_state == S_DONE);
    assign done_pulse = r_done_pulse;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer with TICK_DIV=4: expectations are queued
// with a target clock edge and compared by a monitor after that edge.
module tb_countdown_timer;

    localparam int TICK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        load;
    logic [15:0] load_val;
    logic        start_stop;
    logic [15:0] q;
    logic        running;
    logic        expired;
    logic        done_pulse;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        string       tag;
        int          at;
        logic [15:0] q;
        logic        run;
        logic        exp;
        logic        dp;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    countdown_timer #(.TICK_DIV(TICK_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .load       (load),
        .load_val   (load_val),
        .start_stop (start_stop),
        .q          (q),
        .running    (running),
        .expired    (expired),
        .done_pulse (done_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, expv, cyc);
        end
    endtask

    // Expectation for the outputs seen after the edge n edges from the last one.
    task automatic expect_at(input string tag, input int n, input logic [15:0] qv,
                             input logic run, input logic exp, input logic dp);
        exp_t x;
        x.tag = tag;
        x.at  = cyc + n;
        x.q   = qv;
        x.run = run;
        x.exp = exp;
        x.dp  = dp;
        sb.push_back(x);
    endtask

    task automatic pulse(input logic c, input logic l, input logic s, input logic [15:0] v);
        clear      = c;
        load       = l;
        start_stop = s;
        load_val   = v;
        @(negedge clk);
        clear      = 1'b0;
        load       = 1'b0;
        start_stop = 1'b0;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    always begin
        @(negedge clk);
        #1;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            check({e.tag, ".edge"}, 32'(cyc), 32'(e.at));
            check({e.tag, ".q"},    {16'h0, q},          {16'h0, e.q});
            check({e.tag, ".run"},  {31'h0, running},    {31'h0, e.run});
            check({e.tag, ".exp"},  {31'h0, expired},    {31'h0, e.exp});
            check({e.tag, ".dp"},   {31'h0, done_pulse}, {31'h0, e.dp});
        end
    end

    initial begin
        rst = 1'b1;
        repeat (2) begin
            clear      = 1'($urandom);
            load       = 1'($urandom);
            start_stop = 1'($urandom);
            load_val   = 16'($urandom);
            @(negedge clk);
        end
        rst = 1'b0;
        clear = 1'b0; load = 1'b0; start_stop = 1'b0; load_val = 16'h0;
        expect_at("reset", 0, 16'h0000, 1'b0, 1'b0, 1'b0);

        pulse(1'b0, 1'b0, 1'b1, 16'h0);
        expect_at("ss_zero", 0, 16'h0000, 1'b0, 1'b0, 1'b0);
        expect_at("ss_zero_later", 5, 16'h0000, 1'b0, 1'b0, 1'b0);
        wait_edges(5);

        // Basic count
        pulse(1'b0, 1'b1, 1'b0, 16'h0012);
        pulse(1'b0, 1'b0, 1'b1, 16'h0);
        expect_at("cnt_start", 1,  16'h0012, 1'b1, 1'b0, 1'b0);
        expect_at("cnt_4",     4,  16'h0011, 1'b1, 1'b0, 1'b0);
        expect_at("cnt_6",     6,  16'h0011, 1'b1, 1'b0, 1'b0);
        expect_at("cnt_8",     8,  16'h0010, 1'b1, 1'b0, 1'b0);
        expect_at("cnt_12",    12, 16'h0009, 1'b1, 1'b0, 1'b0);
        wait_edges(12);
        pulse(1'b1, 1'b0, 1'b0, 16'h0);
        expect_at("clear", 0, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Borrow chain
        pulse(1'b0, 1'b1, 1'b0, 16'h0100);
        pulse(1'b0, 1'b0, 1'b1, 16'h0);
        expect_at("borrow_0100", 4, 16'h0059, 1'b1, 1'b0, 1'b0);
        wait_edges(4);
        pulse(1'b1, 1'b0, 1'b0, 16'h0);
        pulse(1'b0, 1'b1, 1'b0, 16'h1000);
        pulse(1'b0, 1'b0, 1'b1, 16'h0);
        expect_at("borrow_1000", 4, 16'h0959, 1'b1, 1'b0, 1'b0);
        wait_edges(4);
        pulse(1'b1, 1'b0, 1'b0, 16'h0);

        // Expiry
        pulse(1'b0, 1'b1, 1'b0, 16'h0002);
        pulse(1'b0, 1'b0, 1'b1, 16'h0);
        expect_at("exp_4",  4, 16'h0001, 1'b1, 1'b0, 1'b0);
        expect_at("exp_7",  7, 16'h0001, 1'b1, 1'b0, 1'b0);
        expect_at("exp_8",  8, 16'h0000, 1'b0, 1'b1, 1'b1);
        expect_at("exp_9",  9, 16'h0000, 1'b0, 1'b1, 1'b0);
        wait_edges(9);
        pulse(1'b0, 1'b0, 1'b1, 16'h0);
        expect_at("done_ss1", 0, 16'h0000, 1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 16'h0);
        expect_at("done_ss2", 3, 16'h0000, 1'b0, 1'b1, 1'b0);
        wait_edges(3);
        pulse(1'b0, 1'b1, 1'b0, 16'h0005);
        expect_at("done_load", 0, 16'h0005, 1'b0, 1'b0, 1'b0);

        // Pause / resume
        pulse(1'b0, 1'b1, 1'b0, 16'h0003);
        pulse(1'b0, 1'b0, 1'b1, 16'h0);
        wait_edges(1);
        pulse(1'b0, 1'b0, 1'b1, 16'h0);
        expect_at("pause",      0,  16'h0003, 1'b0, 1'b0, 1'b0);
        expect_at("pause_hold", 20, 16'h0003, 1'b0, 1'b0, 1'b0);
        wait_edges(20);
        pulse(1'b0, 1'b0, 1'b1, 16'h0);
        expect_at("resume",   0, 16'h0003, 1'b1, 1'b0, 1'b0);
        expect_at("resume_1", 1, 16'h0003, 1'b1, 1'b0, 1'b0);
        expect_at("resume_2", 2, 16'h0002, 1'b1, 1'b0, 1'b0);
        wait_edges(2);
        wait_edges(3);
        pulse(1'b0, 1'b0, 1'b1, 16'h0);
        expect_at("tick_pause", 0, 16'h0001, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 16'h0);
        expect_at("tick_res_3", 3, 16'h0001, 1'b1, 1'b0, 1'b0);
        expect_at("tick_res_4", 4, 16'h0000, 1'b0, 1'b1, 1'b1);
        wait_edges(4);

        // Clamp and priority
        pulse(1'b0, 1'b1, 1'b0, 16'h9F7A);
        expect_at("clamp", 0, 16'h9959, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 16'h0);
        wait_edges(2);
        pulse(1'b0, 1'b1, 1'b0, 16'h0100);
        expect_at("load_in_run",   0, 16'h9959, 1'b1, 1'b0, 1'b0);
        expect_at("load_in_run_t", 1, 16'h9958, 1'b1, 1'b0, 1'b0);
        wait_edges(1);
        pulse(1'b1, 1'b1, 1'b0, 16'h1234);
        expect_at("clear_load",   0, 16'h0000, 1'b0, 1'b0, 1'b0);
        expect_at("clear_load_4", 4, 16'h0000, 1'b0, 1'b0, 1'b0);
        wait_edges(4);
        pulse(1'b0, 1'b1, 1'b1, 16'h0042);
        expect_at("load_ss",   0, 16'h0042, 1'b0, 1'b0, 1'b0);
        expect_at("load_ss_5", 5, 16'h0042, 1'b0, 1'b0, 1'b0);
        wait_edges(5);

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
        #2;
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
